snake_direction_queue: RTL and testbench
========================================

# snake_direction_queue

- Sits directly downstream of the push-button debouncer.
- Converts debounced button levels into single-press direction commands.
- Filters illegal turns and buffers up to `c_QUEUE_DEPTH` pending turns.
- Commits one turn per game step (`i_Tick`) to the heading register used by the snake movement logic.

## Interface
Parameters:
- `c_QUEUE_DEPTH`, default 2: pending-turn FIFO depth; legal range 1–8.

Ports:
- `i_Clk`, input, 1: system clock; every register updates on its rising edge.
- `i_Reset`, input, 1: reset, synchronous and active-high.
- `i_Buttons`, input, 4: debounced button levels; bit0 up, bit1 down, bit2 left, bit3 right.
- `i_Tick`, input, 1: game-step strobe, one cycle wide; pops one queued turn.
- `o_Direction`, output, 2: committed heading; 00 up, 01 down, 10 left, 11 right.
- `o_Turn`, output, 1: one-cycle pulse in the cycle `o_Direction` changes.
- `o_Dropped`, output, 1: one-cycle pulse when an accepted-edge press is discarded because the queue is full.
- `o_Pending`, output, 4: number of queued turns, 0 to `c_QUEUE_DEPTH`.

## Operation
**Edge detection**
- A previous-level register `r_PrevButtons` is compared with `i_Buttons` each cycle.
- A rising edge is `i_Buttons & ~r_PrevButtons`.
- Only edges count; a held button yields exactly one press.

**Multiple edges**
- When several edges occur in one cycle, only the highest-priority one is taken: up > down > left > right.
- The others are discarded silently.

**Reference direction**
- If the queue is non-empty, the reference is the tail entry.
- Otherwise it is `o_Direction`.
- A candidate equal to the reference is rejected: nothing is enqueued and there is no `o_Dropped` pulse.

**Reverse filter**
- Opposite direction is `dir ^ 2'b01`; see Configuration for whether opposites are rejected.

**Enqueue**
- A surviving candidate is written at the tail, and `o_Pending` increments.
- If the queue is full, the candidate is discarded and `o_Dropped` pulses.

**Pop**
- When `i_Tick` is high and the queue is non-empty, the head entry is written to `o_Direction`, `o_Pending` decrements, and `o_Turn` pulses.
- When `i_Tick` is high and the queue is empty, nothing changes and there is no pulse.

**Simultaneous push and pop**
- Both are performed in the same cycle.
- A full queue accepts the push when a pop occurs in the same cycle; `o_Pending` is unchanged and there is no drop.
- The reference direction for that push is the pre-pop tail (or the pre-pop `o_Direction` when the queue is empty).
- With an empty queue, push and pop in the same cycle: the candidate is enqueued and is not committed until a later tick.

**FIFO pointers**
- Head and tail pointers wrap modulo `c_QUEUE_DEPTH`.
- Full and empty are derived from a separate count register, not from pointer equality.

## Timing
**Reset values**
- `o_Direction` = 11 (right).
- `o_Turn` = 0, `o_Dropped` = 0, `o_Pending` = 0.
- Queue pointers = 0.
- `r_PrevButtons` = 4'b1111, so buttons held through reset produce no press.

**Reset mid-operation**
- Reset flushes all queued turns in the next cycle regardless of `i_Tick` or `i_Buttons`.

**Latency**
- Edge sampled at cycle n: `o_Pending` reflects it at n+1.
- `i_Tick` sampled at cycle m with a non-empty queue: `o_Direction` and `o_Turn` are updated at m+1.
- `o_Dropped` is asserted at n+1 for an edge sampled at n.

**Registered outputs**
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
`SNAKE_REVERSE_FILTER_EN`:
- Defined: a candidate opposite to the reference direction is rejected with no enqueue and no `o_Dropped` pulse.
- Undefined: opposite-direction presses are enqueued like any other turn; equal-direction presses are still rejected.

## Structure
**Shared package `snake_pkg`**
- Direction constants `c_DIR_UP`, `c_DIR_DOWN`, `c_DIR_LEFT`, `c_DIR_RIGHT`.
- The 2-bit direction width.
- Opposite-direction helper function.
- Button bit-index constants, shared with the debouncer and display logic.

**Sub-module `button_edge_detector`**
- Holds the previous-level register, the rising-edge mask and the priority encoder.
- Outputs: `o_Press` (1 bit) and `o_PressDir` (2 bits).
- The FIFO and commit logic stay in the top module.

## Test plan
1. Reset, then up press (`i_Buttons` 0000 -> 0001) -> `o_Pending`=1 next cycle; `i_Tick` -> `o_Direction`=00, `o_Turn` high one cycle, `o_Pending`=0.
2. Hold left for 50 cycles with three ticks -> exactly one enqueue; `o_Direction`=10 after the first tick; later ticks give no `o_Turn`.
3. Heading right, press left with `SNAKE_REVERSE_FILTER_EN` defined -> `o_Pending` stays 0. Without the macro -> `o_Pending`=1 and the tick commits 10.
4. Depth 2, heading right: press up, left, down -> up and left queued, then `o_Pending`=2; the down press pulses `o_Dropped`. Two ticks commit 00 then 10.
5. Full queue; a press with a non-reference direction arrives in the same cycle as `i_Tick` -> pop and push both occur, `o_Pending` stays 2, no `o_Dropped`.
6. Assert `i_Reset` with 2 pending and up+right edges in the same cycle -> next cycle `o_Pending`=0 and `o_Direction`=11; subsequent ticks produce no `o_Turn`.

Source files
------------

// File: rtl/snake_direction_queue_pkg.sv
// Shared snake game definitions: direction encoding, button bit indices and helpers.
// Used by the debouncer, the direction queue and the display logic.
package snake_pkg;

  localparam int c_DIR_W = 2;

  typedef logic [c_DIR_W-1:0] dir_t;

  localparam dir_t c_DIR_UP    = 2'b00;
  localparam dir_t c_DIR_DOWN  = 2'b01;
  localparam dir_t c_DIR_LEFT  = 2'b10;
  localparam dir_t c_DIR_RIGHT = 2'b11;

  localparam int c_BTN_UP    = 0;
  localparam int c_BTN_DOWN  = 1;
  localparam int c_BTN_LEFT  = 2;
  localparam int c_BTN_RIGHT = 3;

  // The encoding pairs up/down and left/right, so flipping bit 0 gives the reverse heading.
  function automatic dir_t opposite_dir(input dir_t dir);
    return dir ^ 2'b01;
  endfunction

endpackage

// File: rtl/snake_direction_queue_if.sv
// Button/tick inputs and heading/status outputs of the snake direction queue.
// master drives the buttons and tick; slave is the queue itself.
interface snake_direction_queue_if;
  import snake_pkg::*;

  logic [3:0] i_Buttons;
  logic       i_Tick;
  dir_t       o_Direction;
  logic       o_Turn;
  logic       o_Dropped;
  logic [3:0] o_Pending;

  modport master (
    output i_Buttons,
    output i_Tick,
    input  o_Direction,
    input  o_Turn,
    input  o_Dropped,
    input  o_Pending
  );

  modport slave (
    input  i_Buttons,
    input  i_Tick,
    output o_Direction,
    output o_Turn,
    output o_Dropped,
    output o_Pending
  );

endinterface

// File: rtl/snake_direction_queue_edge_detector.sv
// Turns debounced button levels into a single press per rising edge, picking
// the highest-priority edge (up > down > left > right) when several arrive together.
module button_edge_detector
  import snake_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_Buttons,
  output logic       o_Press,
  output dir_t       o_PressDir
);

  logic [3:0] r_PrevButtons;
  logic [3:0] rising_edges;

  // Resetting to all-ones means a button held through reset never counts as a press.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_PrevButtons <= 4'b1111;
    end else begin
      r_PrevButtons <= i_Buttons;
    end
  end

  always_comb begin
    rising_edges = i_Buttons & ~r_PrevButtons;
    o_Press      = |rising_edges;
    o_PressDir   = c_DIR_RIGHT;
    if (rising_edges[c_BTN_UP]) begin
      o_PressDir = c_DIR_UP;
    end else if (rising_edges[c_BTN_DOWN]) begin
      o_PressDir = c_DIR_DOWN;
    end else if (rising_edges[c_BTN_LEFT]) begin
      o_PressDir = c_DIR_LEFT;
    end
  end

endmodule

// File: rtl/snake_direction_queue.sv
// Buffers legal turn presses and commits one per game tick to the snake heading.
// Define SNAKE_REVERSE_FILTER_EN to also reject presses that reverse the reference heading.
module snake_direction_queue
  import snake_pkg::*;
#(
  parameter int c_QUEUE_DEPTH = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  snake_direction_queue_if.slave bus
);

  localparam logic [2:0] c_LAST_PTR   = 3'(c_QUEUE_DEPTH - 1);
  localparam logic [3:0] c_FULL_COUNT = 4'(c_QUEUE_DEPTH);

  dir_t       r_fifo [8];
  logic [2:0] r_head;
  logic [2:0] r_tail;
  logic [3:0] r_count;
  dir_t       r_direction;
  logic       r_turn;
  logic       r_dropped;

  logic       press;
  dir_t       press_dir;
  logic [2:0] tail_last;
  logic [2:0] head_next;
  logic [2:0] tail_next;
  dir_t       ref_dir;
  logic       queue_full;
  logic       candidate_ok;
  logic       do_pop;
  logic       do_push;
  logic       do_drop;

  button_edge_detector u_edge (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Buttons  (bus.i_Buttons),
    .o_Press    (press),
    .o_PressDir (press_dir)
  );

  // New presses are judged against the last queued turn, or the live heading when idle.
  always_comb begin
    tail_last  = (r_tail == 3'd0) ? c_LAST_PTR : r_tail - 3'd1;
    head_next  = (r_head == c_LAST_PTR) ? 3'd0 : r_head + 3'd1;
    tail_next  = (r_tail == c_LAST_PTR) ? 3'd0 : r_tail + 3'd1;
    ref_dir    = (r_count != 4'd0) ? r_fifo[tail_last] : r_direction;
    queue_full = (r_count == c_FULL_COUNT);

    candidate_ok = press && (press_dir != ref_dir);
`ifdef SNAKE_REVERSE_FILTER_EN
    candidate_ok = candidate_ok && (press_dir != opposite_dir(ref_dir));
`else
    candidate_ok = candidate_ok;
`endif

    do_pop  = bus.i_Tick && (r_count != 4'd0);
    do_push = candidate_ok && (!queue_full || do_pop);
    do_drop = candidate_ok && queue_full && !do_pop;
  end

  always_ff @(posedge i_Clk) begin
    if (do_push) begin
      r_fifo[r_tail] <= press_dir;
    end
  end

  // A pop in the same cycle frees the slot a full queue needs for the incoming push.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_head      <= 3'd0;
      r_tail      <= 3'd0;
      r_count     <= 4'd0;
      r_direction <= c_DIR_RIGHT;
      r_turn      <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_turn    <= do_pop;
      r_dropped <= do_drop;
      if (do_pop) begin
        r_direction <= r_fifo[r_head];
        r_head      <= head_next;
      end
      if (do_push) begin
        r_tail <= tail_next;
      end
      case ({do_push, do_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.o_Direction = r_direction;
  assign bus.o_Turn      = r_turn;
  assign bus.o_Dropped   = r_dropped;
  assign bus.o_Pending   = r_count;

endmodule

// File: tb/tb_snake_direction_queue.sv
// Directed self-checking bench for snake_direction_queue at the default depth of 2.
// Expected values for reversing presses follow SNAKE_REVERSE_FILTER_EN.
module tb_snake_direction_queue;
  import snake_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  snake_direction_queue_if bus ();

  snake_direction_queue #(.c_QUEUE_DEPTH(2)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] buttons, input logic tick);
    bus.i_Buttons = buttons;
    bus.i_Tick    = tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input logic [3:0] buttons, input logic tick);
    rst = 1'b1;
    applyStimulus(buttons, tick);
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] exp_dir,
                             input logic exp_turn, input logic exp_drop,
                             input logic [3:0] exp_pend);
    vectors++;
    assert (bus.o_Direction === exp_dir) else begin
      miscompares++;
      $error("[TB] FAIL %s direction: got %b expected %b", tag, bus.o_Direction, exp_dir);
    end
    assert (bus.o_Turn === exp_turn) else begin
      miscompares++;
      $error("[TB] FAIL %s turn: got %b expected %b", tag, bus.o_Turn, exp_turn);
    end
    assert (bus.o_Dropped === exp_drop) else begin
      miscompares++;
      $error("[TB] FAIL %s dropped: got %b expected %b", tag, bus.o_Dropped, exp_drop);
    end
    assert (bus.o_Pending === exp_pend) else begin
      miscompares++;
      $error("[TB] FAIL %s pending: got %0d expected %0d", tag, bus.o_Pending, exp_pend);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.i_Buttons = 4'b0000;
    bus.i_Tick    = 1'b0;

    applyReset(4'b0000, 1'b0);
    checkOutput("reset", 2'b11, 1'b0, 1'b0, 4'd0);

    // single up press, then commit it
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("up_enq", 2'b11, 1'b0, 1'b0, 4'd1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("up_pop", 2'b00, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("up_idle", 2'b00, 1'b0, 1'b0, 4'd0);

    // left held for 50 cycles with three ticks gives a single turn
    applyStimulus(4'b0100, 1'b0);
    checkOutput("hold_enq", 2'b00, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 49; i++) begin
      applyStimulus(4'b0100, (i == 5 || i == 20 || i == 35));
      if (i == 5)
        checkOutput("hold_tick1", 2'b10, 1'b1, 1'b0, 4'd0);
      else if (i == 20 || i == 35)
        checkOutput("hold_tickn", 2'b10, 1'b0, 1'b0, 4'd0);
    end
    applyStimulus(4'b0000, 1'b0);

    // heading right, press left (reverse)
    applyReset(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0100, 1'b0);
`ifdef SNAKE_REVERSE_FILTER_EN
    checkOutput("rev_press", 2'b11, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rev_tick", 2'b11, 1'b0, 1'b0, 4'd0);
`else
    checkOutput("rev_press", 2'b11, 1'b0, 1'b0, 4'd1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rev_tick", 2'b10, 1'b1, 1'b0, 4'd0);
`endif

    // fill depth 2 with up, left; down is dropped
    applyReset(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("fill_two", 2'b11, 1'b0, 1'b0, 4'd2);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("fill_drop", 2'b11, 1'b0, 1'b1, 4'd2);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("drop_clear", 2'b11, 1'b0, 1'b0, 4'd2);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("fill_pop1", 2'b00, 1'b1, 1'b0, 4'd1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("fill_pop2", 2'b10, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("empty_tick", 2'b10, 1'b0, 1'b0, 4'd0);

    // full queue (up, right), down press together with a tick
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("full_again", 2'b10, 1'b0, 1'b0, 4'd2);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("push_pop", 2'b00, 1'b1, 1'b0, 4'd2);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("pp_pop1", 2'b11, 1'b1, 1'b0, 4'd1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("pp_pop2", 2'b01, 1'b1, 1'b0, 4'd0);

    // two pending, then reset with up+right edges and a tick
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("pre_flush", 2'b01, 1'b0, 1'b0, 4'd2);
    applyStimulus(4'b0000, 1'b0);
    applyReset(4'b1001, 1'b1);
    checkOutput("flush", 2'b11, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("flush_tick1", 2'b11, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("flush_tick2", 2'b11, 1'b0, 1'b0, 4'd0);

    // simultaneous down+left edges: down wins
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0110, 1'b0);
    checkOutput("prio_enq", 2'b11, 1'b0, 1'b0, 4'd1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("prio_pop", 2'b01, 1'b1, 1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
